secuenciador_pc: RTL

//  Next-PC sequencer for the multicycle datapath. Owns the PC register and runs the

---
 rtl/secuenciador_pc.sv | 127 ++++++++++++
 1 files changed

// File: rtl/secuenciador_pc.sv
// Next-PC sequencer: owns the PC, runs the fetch handshake with instruction
// memory and selects sequential/branch/jump/jr targets at the end of EXEC.
module secuenciador_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        ERROR
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        flush_q, flush_d;

    logic [31:0] target_pc;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        target_pc = pc_plus4;
        redirect  = 1'b1;
        if (jr) begin
            target_pc = jr_addr & ~32'h3;
        end else if (jump) begin
            target_pc = {pc_plus4[31:28], jump_idx, 2'b00};
        end else if (branch && zero) begin
            target_pc = pc_plus4 + (imm_ext << 2);
        end else begin
            redirect  = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        flush_d    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_d    = EXEC;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                // A late ack on the final allowed wait cycle still wins over the timeout.
                if (imem_ack) begin
                    state_d    = EXEC;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == MAX_WAIT_C) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_d = FETCH;
                    pc_d    = target_pc;
                    flush_d = redirect;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            wait_cnt_q <= 8'd0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_cnt_q <= wait_cnt_d;
            flush_q    <= flush_d;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == WAIT);
    assign imem_addr   = imem_req ? pc_q : 32'd0;
    assign instr_valid = (state_q == EXEC);
    assign pc_out      = pc_q;
    assign flush       = flush_q;
    assign timeout_err = (state_q == ERROR);

endmodule
